// File: rtl/irq_req_arbiter4.sv
// Purpose : four-input request latch and arbiter feeding the 4-to-2 encoder with a single hot grant.
// Latency : req at edge k sets pending after k; grant/valid appear after edge k+1 when the arbiter is idle.
// Backpressure: a grant is held until ack (or withdrawn after TIMEOUT cycles); later requests wait in pending.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req[3:0]   in   request pulses, each high cycle sets the matching pending bit
//   ack        in   acknowledge of the current grant, only honoured while granting
//   grant[3:0] out  registered one-hot grant, zero when valid=0
//   grant_idx  out  registered binary index of the grant, holds when valid=0
//   valid      out  registered, high exactly while a grant is presented
//   pending    out  registered pending-request vector
//   timeout    out  registered one-cycle pulse when a grant is withdrawn unacknowledged
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed
// priority with the highest index winning, matching the downstream encoder.

module irq_req_arbiter4 #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       valid,
  output logic [3:0] pending,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  // Last counter value before the grant is withdrawn; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] CNT_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      grant_idx_q, grant_idx_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      clr;
  logic [1:0]      win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Scan from start upward with wrap; iterating offsets from far to near lets the
  // nearest set bit overwrite the others and win.
  function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] best;
    best = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (p[idx]) best = idx;
    end
    return best;
  endfunction

  assign win = pick(pending_q, ptr_q);
`else
  // Fixed priority: later (higher) indices overwrite lower ones, so bit 3 wins.
  function automatic logic [1:0] pick(input logic [3:0] p);
    logic [1:0] best;
    best = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) best = 2'(i);
    end
    return best;
  endfunction

  assign win = pick(pending_q);
`endif

  // Only an acknowledged grant clears its pending bit; a same-cycle req re-sets it.
  assign clr = (state_q == GRANT && ack) ? (4'b0001 << grant_idx_q) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    pending_d   = (pending_q & ~clr) | req;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // Selection looks only at registered pending, never at this cycle's req.
        if (|pending_q) begin
          state_d     = GRANT;
          grant_d     = 4'b0001 << win;
          grant_idx_d = win;
          valid_d     = 1'b1;
          cnt_d       = '0;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          valid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = grant_idx_q + 2'd1;
`endif
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          // Withdraw without clearing pending; the request will be re-served later.
          state_d   = RELEASE;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d     = grant_idx_q + 2'd1;
`endif
        end else if (TO_EN) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RELEASE: begin
        // One forced gap cycle so the encoder input always passes through zero.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 4'b0000;
      grant_q     <= 4'b0000;
      grant_idx_q <= 2'd0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign valid     = valid_q;
  assign pending   = pending_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_irq_req_arbiter4.sv
// Purpose : self-checking bench for irq_req_arbiter4 with directed scenarios and random traffic.
// Latency : each step drives inputs, waits one rising edge, and compares all outputs 1ns later.
// Backpressure: ack is driven directly or randomly; waits for a grant are cycle-bounded.

module tb_irq_req_arbiter4;

  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       valid;
  logic [3:0] pending;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0=idle, 1=granting, 2=gap.
  int m_phase;
  int m_owner;
  int m_ptr;
  int m_age;
  bit m_tout;
  bit m_pend [4];

  irq_req_arbiter4 #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (valid),
    .pending   (pending),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_pend[k];
    return v;
  endfunction

  // Winner over the current pending set, or -1 if nothing is pending.
  function automatic int model_pick();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++)
      if (m_pend[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
    for (int k = 3; k >= 0; k--)
      if (m_pend[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic a, input logic rn);
    int w;
    if (!rn) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_tout = 0;
      for (int k = 0; k < 4; k++) m_pend[k] = 0;
      return;
    end
    w = model_pick();
    m_tout = 0;
    for (int k = 0; k < 4; k++)
      m_pend[k] = (m_pend[k] && !(m_phase == 1 && a && m_owner == k)) || r[k];
    case (m_phase)
      0: if (w >= 0) begin m_phase = 1; m_owner = w; m_age = 0; end
      1: begin
        if (a) begin
          m_ptr = (m_owner + 1) % 4; m_phase = 2;
        end else if (TIMEOUT != 0 && m_age == TIMEOUT - 1) begin
          m_ptr = (m_owner + 1) % 4; m_phase = 2; m_tout = 1;
        end else begin
          m_age++;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock step: drive, clock, advance the model, compare every output.
  task automatic cyc(input logic [3:0] r, input logic a, input logic rn);
    req = r; ack = a; rst_n = rn;
    @(posedge clk);
    model_step(r, a, rn);
    #1;
    chk("valid",     valid,     (m_phase == 1) ? 1 : 0);
    chk("grant",     grant,     (m_phase == 1) ? (32'd1 << m_owner) : 0);
    chk("grant_idx", grant_idx, m_owner);
    chk("pending",   pending,   m_pend_vec());
    chk("timeout",   timeout,   m_tout);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < budget) begin
      cyc(4'b0000, 1'b0, 1'b1);
      n++;
    end
    chk(tag, valid, 1);
  endtask

  initial begin
    int vcnt;
    int tcnt;
    int aprob;
    logic [3:0] r;
    logic a;
    logic rn;

    req = 4'b0000; ack = 1'b0; rst_n = 1'b0;
    m_phase = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_tout = 0;
    for (int k = 0; k < 4; k++) m_pend[k] = 0;

    // Reset state
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("rst_valid",   valid,     0);
    chk("rst_grant",   grant,     0);
    chk("rst_pending", pending,   0);
    chk("rst_idx",     grant_idx, 0);
    chk("rst_timeout", timeout,   0);

    // Stray ack while idle
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1);
    chk("stray_valid",   valid,   0);
    chk("stray_pending", pending, 0);

    // Single request latency and ack
    cyc(4'b0001, 1'b0, 1'b1);
    chk("lat_pending", pending, 4'b0001);
    chk("lat_valid0",  valid,   0);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("lat_valid1",  valid,     1);
    chk("lat_grant",   grant,     4'b0001);
    chk("lat_idx",     grant_idx, 0);
    cyc(4'b0000, 1'b1, 1'b1);
    chk("ack_valid",   valid,   0);
    chk("ack_pending", pending, 0);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("gap_valid",   valid,   0);
    chk("gap_grant",   grant,   0);

    // Simultaneous requests from a fresh pointer
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      wait_valid("sim_wait", 8);
`ifdef ARB_ROUND_ROBIN_EN
      chk("sim_idx", grant_idx, n);
`else
      chk("sim_idx", grant_idx, 3 - n);
`endif
      cyc(4'b0000, 1'b1, 1'b1);
    end
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("sim_pending_end", pending, 0);
    chk("sim_valid_end",   valid,   0);

    // Timeout on an unacknowledged grant
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1);
    vcnt = 0; tcnt = 0;
    for (int k = 0; k < TIMEOUT + 2; k++) begin
      cyc(4'b0000, 1'b0, 1'b1);
      if (valid === 1'b1) vcnt++;
      if (timeout === 1'b1) tcnt++;
    end
    chk("to_valid_cycles", vcnt,    TIMEOUT);
    chk("to_pulses",       tcnt,    1);
    chk("to_pending",      pending, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("to_regrant_valid", valid,     1);
    chk("to_regrant_idx",   grant_idx, 1);
    cyc(4'b0000, 1'b1, 1'b1);

    // Ack on the last cycle before timeout takes priority
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < TIMEOUT - 1; k++) cyc(4'b0000, 1'b0, 1'b1);
    chk("late_ack_still_valid", valid, 1);
    cyc(4'b0000, 1'b1, 1'b1);
    chk("late_ack_no_timeout", timeout, 0);
    chk("late_ack_pending",    pending, 0);

    // Set wins over clear
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("swc_idx", grant_idx, 2);
    cyc(4'b0100, 1'b1, 1'b1);
    chk("swc_pending", pending, 4'b0100);
    chk("swc_valid0",  valid,   0);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("swc_regrant_valid", valid,     1);
    chk("swc_regrant_idx",   grant_idx, 2);
    cyc(4'b0000, 1'b1, 1'b1);

    // Reset mid-grant, with req and ack ignored during reset
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("mid_valid", valid, 1);
    chk("mid_grant", grant, 4'b0100);
    cyc(4'b1000, 1'b1, 1'b0);
    chk("mid_rst_grant",   grant,     0);
    chk("mid_rst_valid",   valid,     0);
    chk("mid_rst_pending", pending,   0);
    chk("mid_rst_idx",     grant_idx, 0);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(4'b0000, 1'b0, 1'b1);
      if (valid !== 1'b0) vcnt++;
    end
    chk("mid_no_regrant", vcnt, 0);

    // Random traffic against the model; later phase acks rarely to provoke timeouts
    for (int k = 0; k < 800; k++) begin
      aprob = (k < 400) ? 3 : 25;
      r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      a  = ($urandom_range(0, aprob - 1) == 0);
      rn = ($urandom_range(0, 149) != 0);
      cyc(r, a, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
